// File: rtl/udp_rx_if.sv
// ---------------------------------------------------------------------------
// udp_rx_if : GMII receive byte stream plus the packed payload outputs of the
// UDP receive parser.
//   gmii_rx_dv / gmii_rxd        : byte valid / received byte (from the MAC side)
//   rec_en / rec_data            : payload word strobe / packed 32-bit word
//   rec_pkt_done / rec_byte_num  : end-of-payload pulse / payload byte count
// master : drives the GMII side, observes the payload side (bench / source)
// slave  : the parser itself
// ---------------------------------------------------------------------------
interface udp_rx_if;
   logic        gmii_rx_dv;
   logic [7:0]  gmii_rxd;
   logic        rec_en;
   logic [31:0] rec_data;
   logic        rec_pkt_done;
   logic [15:0] rec_byte_num;

   modport master (
      output gmii_rx_dv, gmii_rxd,
      input  rec_en, rec_data, rec_pkt_done, rec_byte_num
   );

   modport slave (
      input  gmii_rx_dv, gmii_rxd,
      output rec_en, rec_data, rec_pkt_done, rec_byte_num
   );
endinterface

// File: rtl/udp_rx.sv
// ---------------------------------------------------------------------------
// udp_rx : Ethernet/IPv4/UDP receive parser on the GMII byte stream.
// Filters on destination MAC (board or broadcast), EtherType IPv4, protocol
// UDP and destination IP, strips all headers and packs the UDP payload
// big-endian into 32-bit words. FCS is not checked.
// Ports:
//   gmii_rx_clk : 125 MHz receive clock
//   sys_rst_n   : asynchronous active-low reset
//   rx (slave)  : gmii_rx_dv/gmii_rxd in, rec_en/rec_data/rec_pkt_done/
//                 rec_byte_num out
// ---------------------------------------------------------------------------
module udp_rx #(
   parameter logic [47:0] BOARD_MAC = 48'h112233445566,
   parameter logic [31:0] BOARD_IP  = 32'hC0A80180
) (
   input  logic     gmii_rx_clk,
   input  logic     sys_rst_n,
   udp_rx_if.slave  rx
);

   localparam logic [2:0] IDLE     = 3'd0;
   localparam logic [2:0] PREAMBLE = 3'd1;
   localparam logic [2:0] ETH_HEAD = 3'd2;
   localparam logic [2:0] IP_HEAD  = 3'd3;
   localparam logic [2:0] UDP_HEAD = 3'd4;
   localparam logic [2:0] RX_DATA  = 3'd5;
   localparam logic [2:0] DROP     = 3'd6;

   logic [2:0]  state;
   logic        wait_idle;
   logic [15:0] cnt;        // byte index inside the current header/preamble
   logic [3:0]  ihl;
   logic [15:0] udp_len;
   logic [15:0] data_cnt;   // payload bytes accepted so far
   logic [31:0] shreg;
   logic        ucast_ok;
   logic        bcast_ok;

   logic        rec_en;
   logic [31:0] rec_data;
   logic        rec_pkt_done;
   logic [15:0] rec_byte_num;

   logic        dv;
   logic [7:0]  rxd;
   logic        ucast_nxt;
   logic        bcast_nxt;
   logic [15:0] pay_len;
   logic        pay_last;
   logic [31:0] word_nxt;
   logic [31:0] word_algn;
   logic [15:0] hdr_last;

   assign dv  = rx.gmii_rx_dv;
   assign rxd = rx.gmii_rxd;

   assign rx.rec_en       = rec_en;
   assign rx.rec_data     = rec_data;
   assign rx.rec_pkt_done = rec_pkt_done;
   assign rx.rec_byte_num = rec_byte_num;

   function automatic logic [7:0] mac_byte(input logic [2:0] idx);
      case (idx)
         3'd0:    mac_byte = BOARD_MAC[47:40];
         3'd1:    mac_byte = BOARD_MAC[39:32];
         3'd2:    mac_byte = BOARD_MAC[31:24];
         3'd3:    mac_byte = BOARD_MAC[23:16];
         3'd4:    mac_byte = BOARD_MAC[15:8];
         default: mac_byte = BOARD_MAC[7:0];
      endcase
   endfunction

   function automatic logic [7:0] ip_byte(input logic [1:0] idx);
      case (idx)
         2'd0:    ip_byte = BOARD_IP[31:24];
         2'd1:    ip_byte = BOARD_IP[23:16];
         2'd2:    ip_byte = BOARD_IP[15:8];
         default: ip_byte = BOARD_IP[7:0];
      endcase
   endfunction

   always_comb begin
      // running match of the destination MAC, restarted on byte 0
      ucast_nxt = ((cnt == 16'd0) || ucast_ok) && (rxd == mac_byte(cnt[2:0]));
      bcast_nxt = ((cnt == 16'd0) || bcast_ok) && (rxd == 8'hFF);
      pay_len   = udp_len - 16'd8;
      pay_last  = (data_cnt + 16'd1) == pay_len;
      word_nxt  = {shreg[23:0], rxd};
      // left-align a short final word: shift by (3 - bytes_in_word_minus_1) bytes
      word_algn = word_nxt << {~data_cnt[1:0], 3'b000};
      hdr_last  = {10'd0, ihl, 2'b00} - 16'd1;
   end

   always_ff @(posedge gmii_rx_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state        <= IDLE;
         wait_idle    <= 1'b1;
         cnt          <= 16'd0;
         ihl          <= 4'd0;
         udp_len      <= 16'd0;
         data_cnt     <= 16'd0;
         shreg        <= 32'd0;
         ucast_ok     <= 1'b0;
         bcast_ok     <= 1'b0;
         rec_en       <= 1'b0;
         rec_data     <= 32'd0;
         rec_pkt_done <= 1'b0;
         rec_byte_num <= 16'd0;
      end else begin
         rec_en       <= 1'b0;
         rec_pkt_done <= 1'b0;

         if (state == IDLE) begin
            // after reset, never lock onto a frame that is already in flight
            if (wait_idle) begin
               if (!dv) wait_idle <= 1'b0;
            end else if (dv) begin
               cnt   <= 16'd1;
               state <= (rxd == 8'h55) ? PREAMBLE : DROP;
            end
         end else if (state == DROP) begin
            if (!dv) state <= IDLE;
         end else if (!dv) begin
            // frame ended early: partial word is discarded, no done pulse
            state <= IDLE;
         end else begin
            case (state)
               PREAMBLE: begin
                  if (rxd == 8'h55 && cnt < 16'd7) begin
                     cnt <= cnt + 16'd1;
                  end else if (rxd == 8'hD5 && cnt == 16'd7) begin
                     cnt   <= 16'd0;
                     state <= ETH_HEAD;
                  end else begin
                     state <= DROP;
                  end
               end

               ETH_HEAD: begin
                  cnt <= cnt + 16'd1;
                  if (cnt < 16'd6) begin
                     ucast_ok <= ucast_nxt;
                     bcast_ok <= bcast_nxt;
                     if (cnt == 16'd5 && !(ucast_nxt || bcast_nxt)) state <= DROP;
                  end else if (cnt == 16'd12) begin
                     if (rxd != 8'h08) state <= DROP;
                  end else if (cnt == 16'd13) begin
                     cnt   <= 16'd0;
                     state <= (rxd == 8'h00) ? IP_HEAD : DROP;
                  end
               end

               IP_HEAD: begin
                  cnt <= cnt + 16'd1;
                  if (cnt == 16'd0) begin
                     ihl <= rxd[3:0];
                     if (rxd[7:4] != 4'd4 || rxd[3:0] < 4'd5) state <= DROP;
                  end else if (cnt == 16'd9 && rxd != 8'd17) begin
                     state <= DROP;
                  end else if (cnt >= 16'd16 && cnt <= 16'd19 && rxd != ip_byte(cnt[1:0])) begin
                     state <= DROP;
                  end else if (cnt == hdr_last) begin
                     // options (if any) have been skipped by running cnt to IHL*4
                     cnt   <= 16'd0;
                     state <= UDP_HEAD;
                  end
               end

               UDP_HEAD: begin
                  cnt <= cnt + 16'd1;
                  if (cnt == 16'd4) begin
                     udp_len[15:8] <= rxd;
                  end else if (cnt == 16'd5) begin
                     udp_len[7:0] <= rxd;
                     if ({udp_len[15:8], rxd} < 16'd8) state <= DROP;
                  end else if (cnt == 16'd7) begin
                     if (udp_len == 16'd8) begin
                        // empty datagram: report completion without any data word
                        rec_pkt_done <= 1'b1;
                        rec_byte_num <= 16'd0;
                        state        <= DROP;
                     end else begin
                        data_cnt <= 16'd0;
                        state    <= RX_DATA;
                     end
                  end
               end

               RX_DATA: begin
                  shreg    <= word_nxt;
                  data_cnt <= data_cnt + 16'd1;
                  if (pay_last) begin
                     rec_en       <= 1'b1;
                     rec_data     <= word_algn;
                     rec_pkt_done <= 1'b1;
                     rec_byte_num <= pay_len;
                     state        <= DROP;
                  end else if (data_cnt[1:0] == 2'd3) begin
                     rec_en   <= 1'b1;
                     rec_data <= word_nxt;
                  end
               end

               default: state <= DROP;
            endcase
         end
      end
   end

endmodule
